// File: rtl/micro_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : micro_seq
// Purpose  : Microprogram sequencer for the picoRISC control unit. Holds the
//            microprogram counter (uPC) that addresses control memory and
//            selects the next uPC each cycle from: sequential increment,
//            microinstruction branch target, multiway (decoder) target, or
//            the top of a small return-address stack. Stalls while a memory
//            access is outstanding and supports halt/start of sequencing.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      system clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      leave HALT, begin at uPC 0
//   halt       in   1      microinstruction field: stop sequencing
//   br_uncnd   in   1      unconditional jump to br_addr
//   br_cond    in   1      jump to br_addr if cond_vec[cond_sel]=1
//   cond_sel   in   SEL_W  condition select
//   cond_vec   in   CW     status/condition flags
//   br_addr    in   AW     microinstruction branch target
//   br_kmbr    in   1      multiway branch: jump to kmbr_addr
//   kmbr_addr  in   AW     address from branch-address decoder
//   call       in   1      push uPC+1, jump to br_addr
//   ret        in   1      pop return stack into uPC
//   wait_req   in   1      current microinstruction needs memory
//   mem_ready  in   1      memory handshake done
//   upc        out  AW     registered microprogram counter
//   running    out  1      1 in RUN or WAIT
//   stall      out  1      1 in WAIT
//   stk_err    out  1      sticky: push on full or pop on empty
// ============================================================================
module micro_seq #(
   parameter int AW    = 8,
   parameter int CW    = 16,
   parameter int SEL_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt,
   input  logic             br_uncnd,
   input  logic             br_cond,
   input  logic [SEL_W-1:0] cond_sel,
   input  logic [CW-1:0]    cond_vec,
   input  logic [AW-1:0]    br_addr,
   input  logic             br_kmbr,
   input  logic [AW-1:0]    kmbr_addr,
   input  logic             call,
   input  logic             ret,
   input  logic             wait_req,
   input  logic             mem_ready,
   output logic [AW-1:0]    upc,
   output logic             running,
   output logic             stall,
   output logic             stk_err
);

   // Stack pointer carries one extra bit so that "full" (== DEPTH) and
   // "empty" (== 0) are distinguishable without a separate flag.
   localparam int PW = $clog2(DEPTH);

   localparam logic [PW:0] c_sp_empty = '0;
   localparam logic [PW:0] c_sp_full  = (PW+1)'(DEPTH);

   // Control-unit states
   localparam logic [1:0] c_st_halt = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_wait = 2'd2;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]    state_q,   state_d;
   logic [AW-1:0] upc_q,     upc_d;
   logic [PW:0]   sp_q,      sp_d;
   logic          stk_err_q, stk_err_d;
   logic [AW-1:0] stk_q [DEPTH];
   logic [AW-1:0] stk_d [DEPTH];

   // -------------------------------------------------------------------------
   // Helper terms
   // -------------------------------------------------------------------------
   logic [AW-1:0] w_upc_inc;   // uPC+1, modulo 2^AW (also the return address)
   logic [PW-1:0] w_push_idx;  // slot written by a push
   logic [PW-1:0] w_top_idx;   // slot read by a pop
   logic          w_stk_empty;
   logic          w_stk_full;
   logic          w_cond_hit;
   logic          w_load;      // a next-uPC load happens this cycle

   assign w_upc_inc   = upc_q + AW'(1);
   assign w_push_idx  = sp_q[PW-1:0];
   assign w_top_idx   = sp_q[PW-1:0] - PW'(1);
   assign w_stk_empty = (sp_q == c_sp_empty);
   assign w_stk_full  = (sp_q == c_sp_full);
   assign w_cond_hit  = cond_vec[cond_sel];

   // -------------------------------------------------------------------------
   // Next-state and next-uPC selection
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      upc_d     = upc_q;
      sp_d      = sp_q;
      stk_err_d = stk_err_q;
      w_load    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         stk_d[i] = stk_q[i];
      end

      // Sequencing control: decides whether a load happens this cycle.
      case (state_q)
         c_st_halt: begin
            // Only start is honoured here; every other input is ignored.
            if (start) begin
               state_d = c_st_run;
               upc_d   = '0;
            end
         end

         c_st_run: begin
            if (halt) begin
               // halt beats everything, including a pending memory wait.
               state_d = c_st_halt;
            end else if (wait_req && !mem_ready) begin
               state_d = c_st_wait;
            end else begin
               w_load = 1'b1;
            end
         end

         c_st_wait: begin
            // Control memory is still addressed by the held uPC, so the
            // microinstruction fields seen now are the ones that caused the
            // wait; the load is performed in the same cycle mem_ready shows.
            if (mem_ready) begin
               if (halt) begin
                  state_d = c_st_halt;
               end else begin
                  state_d = c_st_run;
                  w_load  = 1'b1;
               end
            end
         end

         default: begin
            state_d = c_st_halt;
            upc_d   = '0;
         end
      endcase

      // Next-uPC priority: ret, call, multiway, unconditional, conditional,
      // then sequential. Exactly one source is taken.
      if (w_load) begin
         if (ret) begin
            if (w_stk_empty) begin
               upc_d     = '0;
               stk_err_d = 1'b1;
            end else begin
               upc_d = stk_q[w_top_idx];
               sp_d  = sp_q - (PW+1)'(1);
            end
         end else if (call) begin
            // The jump is taken even when the push is dropped on overflow.
            upc_d = br_addr;
            if (w_stk_full) begin
               stk_err_d = 1'b1;
            end else begin
               stk_d[w_push_idx] = w_upc_inc;
               sp_d              = sp_q + (PW+1)'(1);
            end
         end else if (br_kmbr) begin
            upc_d = kmbr_addr;
         end else if (br_uncnd) begin
            upc_d = br_addr;
         end else if (br_cond && w_cond_hit) begin
            upc_d = br_addr;
         end else begin
            upc_d = w_upc_inc;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Control registers (async reset returns to HALT with an empty stack)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= c_st_halt;
         upc_q     <= '0;
         sp_q      <= c_sp_empty;
         stk_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         upc_q     <= upc_d;
         sp_q      <= sp_d;
         stk_err_q <= stk_err_d;
      end
   end

   // Stack storage has no reset: entries are only read below the pointer,
   // and the pointer itself is cleared by reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         stk_q[i] <= stk_d[i];
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registers only, no input-to-output path
   // -------------------------------------------------------------------------
   assign upc     = upc_q;
   assign running = (state_q == c_st_run) || (state_q == c_st_wait);
   assign stall   = (state_q == c_st_wait);
   assign stk_err = stk_err_q;

endmodule
`default_nettype wire
